// File: rtl/i2c_seq_pkg.sv
// Shared constants for the I2C command sequencer: register map, STATUS bit
// positions, FSM state encoding and the reset divisor.
package i2c_seq_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_PUSH   = 3'd1;
  localparam logic [2:0] ADDR_DVSR   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RSP    = 3'd4;
  localparam logic [2:0] ADDR_CTRL   = 3'd5;

  localparam int ST_BUSY      = 0;
  localparam int ST_CMD_FULL  = 1;
  localparam int ST_RSP_EMPTY = 2;
  localparam int ST_CMD_OVF   = 3;
  localparam int ST_RSP_OVF   = 4;
  localparam int ST_IRQ_PEND  = 5;
  localparam int ST_CMD_COUNT = 8;
  localparam int ST_RSP_COUNT = 16;

  localparam int CMD_RW_BIT = 24;

  localparam logic [15:0] DVSR_RESET = 16'd500;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } seq_state_t;

endpackage

// File: rtl/i2c_seq_fifo.sv
// Synchronous show-ahead FIFO with flush. A pop and a push in the same cycle
// are both honoured, even when the FIFO is full.
module i2c_seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the pointers and count alone
  // decide which entries are valid, so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Avalon-MM command/response sequencer in front of the I2C byte engine.
// Optional interrupt logic is built only when I2C_SEQ_IRQ_EN is defined.
module i2c_cmd_sequencer #(
  parameter int          CMD_DEPTH  = 8,
  parameter int          RSP_DEPTH  = 4,
  parameter logic [15:0] DVSR_RESET = i2c_seq_pkg::DVSR_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        i2c_en,
  output logic [31:0] i2c_data,
  output logic [1:0]  i2c_byteEn,
  output logic [15:0] i2c_dvsr,
  input  logic [31:0] i2c_readData,
  input  logic        i2c_idle,
  output logic        irq
);
  import i2c_seq_pkg::*;

  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RSP_DEPTH) + 1;

  seq_state_t  state, state_nxt;
  logic [1:0]  wait_cnt;
  logic [31:0] data_reg;
  logic [15:0] dvsr_reg;
  logic        cmd_ovf, rsp_ovf, irq_en, irq_pend;
  logic        launch, done, busy, flush_req;
  logic        wr_data, wr_push, wr_dvsr, wr_ctrl, rd_rsp;
  logic [33:0] cmd_dout;
  logic        cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic [CCW-1:0] cmd_count;
  logic [RCW-1:0] rsp_count;
  logic [31:0] rsp_dout;
  logic        rsp_push;
  logic [31:0] rd_mux;

  assign wr_data   = avs_write && (avs_address == ADDR_DATA);
  assign wr_push   = avs_write && (avs_address == ADDR_PUSH);
  assign wr_dvsr   = avs_write && (avs_address == ADDR_DVSR);
  assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
  assign rd_rsp    = avs_read  && (avs_address == ADDR_RSP);
  assign busy      = (state != S_IDLE);
  assign flush_req = wr_ctrl && avs_writedata[2] && !busy;
  assign rsp_push  = done && i2c_data[CMD_RW_BIT];

  i2c_seq_fifo #(.WIDTH(34), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset), .flush(flush_req),
    .push(wr_push), .pop(launch), .din({avs_writedata[1:0], data_reg}),
    .dout(cmd_dout), .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
  );

  i2c_seq_fifo #(.WIDTH(32), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .reset(reset), .flush(flush_req),
    .push(rsp_push), .pop(rd_rsp), .din(i2c_readData),
    .dout(rsp_dout), .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == S_WAIT_START && state_nxt == S_WAIT_START) ?
                  wait_cnt + 1'b1 : 2'd0;
    end
  end

  // NOTE: every signal is given a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:
        if (!cmd_empty && i2c_idle && !flush_req &&
            (!cmd_dout[CMD_RW_BIT] || !rsp_full)) begin
          launch    = 1'b1;
          state_nxt = S_ISSUE;
        end
      S_ISSUE:      state_nxt = S_WAIT_START;
      S_WAIT_START:
        if (!i2c_idle)              state_nxt = S_WAIT_DONE;
        else if (wait_cnt == 2'd2)  state_nxt = S_ISSUE;
      S_WAIT_DONE:
        if (i2c_idle) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg     <= '0;
      dvsr_reg     <= DVSR_RESET;
      i2c_en       <= 1'b0;
      i2c_data     <= '0;
      i2c_byteEn   <= '0;
      i2c_dvsr     <= DVSR_RESET;
      cmd_ovf      <= 1'b0;
      rsp_ovf      <= 1'b0;
      avs_readdata <= '0;
    end else begin
      i2c_en <= (state == S_ISSUE);
      if (wr_data) data_reg <= avs_writedata;
      if (wr_dvsr) dvsr_reg <= avs_writedata[15:0];
      // Divisor is sampled only at launch so it stays stable per transaction.
      if (launch) begin
        i2c_data   <= cmd_dout[31:0];
        i2c_byteEn <= cmd_dout[33:32];
        i2c_dvsr   <= dvsr_reg;
      end
      if (wr_ctrl && avs_writedata[1]) begin
        cmd_ovf <= 1'b0;
        rsp_ovf <= 1'b0;
      end
      if (wr_push && cmd_full && !launch)   cmd_ovf <= 1'b1;
      if (rsp_push && rsp_full && !rd_rsp)  rsp_ovf <= 1'b1;
      avs_readdata <= avs_read ? rd_mux : '0;
    end
  end

`ifdef I2C_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= avs_writedata[0];
      if (wr_ctrl && avs_writedata[1]) irq_pend <= 1'b0;
      if (done) irq_pend <= 1'b1;
    end
  end
  assign irq = irq_en & irq_pend;
`else
  assign irq_en   = 1'b0;
  assign irq_pend = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA: rd_mux = data_reg;
      ADDR_DVSR: rd_mux = {16'd0, dvsr_reg};
      ADDR_STATUS: begin
        rd_mux[ST_BUSY]            = busy;
        rd_mux[ST_CMD_FULL]        = cmd_full;
        rd_mux[ST_RSP_EMPTY]       = rsp_empty;
        rd_mux[ST_CMD_OVF]         = cmd_ovf;
        rd_mux[ST_RSP_OVF]         = rsp_ovf;
        rd_mux[ST_IRQ_PEND]        = irq_pend;
        rd_mux[ST_CMD_COUNT +: 8]  = 8'(cmd_count);
        rd_mux[ST_RSP_COUNT +: 8]  = 8'(rsp_count);
      end
      ADDR_RSP:  rd_mux = rsp_empty ? 32'd0 : rsp_dout;
      ADDR_CTRL: rd_mux = {31'd0, irq_en};
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer with a simple I2C engine model;
// expectations follow I2C_SEQ_IRQ_EN when it is defined for the build.
module tb_i2c_cmd_sequencer;

`ifdef I2C_SEQ_IRQ_EN
  localparam logic IRQ_IMPL = 1'b1;
`else
  localparam logic IRQ_IMPL = 1'b0;
`endif

  localparam logic [2:0] A_DATA = 3'd0, A_PUSH = 3'd1, A_DVSR = 3'd2,
                         A_STATUS = 3'd3, A_RSP = 3'd4, A_CTRL = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        i2c_en;
  logic [31:0] i2c_data;
  logic [1:0]  i2c_byteEn;
  logic [15:0] i2c_dvsr;
  logic [31:0] i2c_readData;
  logic        i2c_idle;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // Engine model: an accepted en pulse makes it busy for eng_len cycles.
  int          eng_len  = 4;
  bit          eng_hold = 1'b0;
  bit          eng_deaf = 1'b0;
  logic [31:0] eng_rdata = '0;
  int          eng_cnt  = 0;
  int          en_count = 0;

  assign i2c_idle     = (eng_cnt == 0) && !eng_hold;
  assign i2c_readData = eng_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i2c_en) begin
      en_count <= en_count + 1;
      if (!eng_deaf && i2c_idle) eng_cnt <= eng_len;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  i2c_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .i2c_en(i2c_en), .i2c_data(i2c_data), .i2c_byteEn(i2c_byteEn),
    .i2c_dvsr(i2c_dvsr), .i2c_readData(i2c_readData), .i2c_idle(i2c_idle),
    .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  // Waits until the command queue is drained and the FSM is back in S_IDLE.
  task automatic wait_done(input string name);
    logic [31:0] s;
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      avs_rd(A_STATUS, s);
      if (!s[0] && s[15:8] == 8'd0) begin ok = 1'b1; break; end
    end
    check({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] s;
    int          base;

    vecs[0] = '{1'b0, A_STATUS, 32'h0,         32'h0000_0004};
    vecs[1] = '{1'b0, A_DVSR,   32'h0,         32'h0000_01F4};
    vecs[2] = '{1'b0, A_CTRL,   32'h0,         32'h0};
    vecs[3] = '{1'b0, A_RSP,    32'h0,         32'h0};
    vecs[4] = '{1'b1, A_DATA,   32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, A_DVSR,   32'hFFFF_1234, 32'h0000_1234};
    vecs[6] = '{1'b1, A_DVSR,   32'h0000_01F4, 32'h0000_01F4};
    vecs[7] = '{1'b1, A_CTRL,   32'h0000_0001, {31'd0, IRQ_IMPL}};
    vecs[8] = '{1'b1, A_CTRL,   32'h0000_0000, 32'h0};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_en",       32'(i2c_en), 32'h0);
    check("rst_data",     i2c_data, 32'h0);
    check("rst_byteen",   32'(i2c_byteEn), 32'h0);
    check("rst_dvsr",     32'(i2c_dvsr), 32'd500);
    check("rst_irq",      32'(irq), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) avs_wr(vecs[i].addr, vecs[i].wdata);
      avs_rd(vecs[i].addr, s);
      check($sformatf("vec%0d", i), s, vecs[i].exp);
    end

    // Single write command: en exactly two cycles after the PUSH edge.
    avs_wr(A_DATA, 32'hA000_1234);
    base = en_count;
    avs_wr(A_PUSH, 32'd1);
    check("t1_en_n0", 32'(i2c_en), 32'h0);
    @(negedge clk);
    check("t1_en_n1", 32'(i2c_en), 32'h0);
    @(negedge clk);
    check("t1_en_n2",   32'(i2c_en), 32'h1);
    check("t1_data",    i2c_data, 32'hA000_1234);
    check("t1_byteen",  32'(i2c_byteEn), 32'd1);
    check("t1_dvsr",    32'(i2c_dvsr), 32'd500);
    @(negedge clk);
    check("t1_en_n3", 32'(i2c_en), 32'h0);
    wait_done("t1");
    check("t1_pulses", 32'(en_count - base), 32'd1);
    avs_rd(A_STATUS, s);
    check("t1_rsp_empty", 32'(s[2]), 32'd1);
    check("t1_irq_pend",  32'(s[5]), 32'(IRQ_IMPL));

    avs_wr(A_CTRL, 32'd1);
    check("irq_on", 32'(irq), 32'(IRQ_IMPL));
    avs_wr(A_CTRL, 32'd2);
    check("irq_cleared", 32'(irq), 32'h0);
    avs_rd(A_STATUS, s);
    check("irq_pend_cleared", 32'(s[5]), 32'h0);

    // Read command returns data through the response FIFO.
    eng_rdata = 32'h0000_ABCD;
    avs_wr(A_DATA, 32'hA105_0000);
    avs_wr(A_PUSH, 32'd2);
    wait_done("t2");
    check("t2_byteen", 32'(i2c_byteEn), 32'd2);
    check("t2_data",   i2c_data, 32'hA105_0000);
    avs_rd(A_RSP, s);
    check("t2_rsp", s, 32'h0000_ABCD);
    avs_rd(A_STATUS, s);
    check("t2_rsp_empty", 32'(s[2]), 32'd1);
    check("t2_rsp_count", 32'(s[23:16]), 32'd0);

    // Command overflow with the engine held busy, then flush.
    eng_hold = 1'b1;
    avs_wr(A_DATA, 32'h2000_0000);
    for (int i = 0; i < 9; i++) avs_wr(A_PUSH, 32'd1);
    avs_rd(A_STATUS, s);
    check("t3_cmd_full",  32'(s[1]), 32'd1);
    check("t3_cmd_ovf",   32'(s[3]), 32'd1);
    check("t3_cmd_count", 32'(s[15:8]), 32'd8);
    check("t3_busy",      32'(s[0]), 32'd0);
    avs_wr(A_CTRL, 32'd6);
    avs_rd(A_STATUS, s);
    check("t3_flush_count", 32'(s[15:8]), 32'd0);
    check("t3_ovf_clear",   32'(s[3]), 32'd0);
    eng_hold = 1'b0;

    // Full response FIFO blocks the next read command until a pop.
    eng_rdata = 32'h0000_BEEF;
    avs_wr(A_DATA, 32'hA100_0000);
    for (int i = 0; i < 4; i++) avs_wr(A_PUSH, 32'd1);
    wait_done("t4_fill");
    avs_rd(A_STATUS, s);
    check("t4_rsp_count4", 32'(s[23:16]), 32'd4);
    base = en_count;
    avs_wr(A_PUSH, 32'd1);
    repeat (20) @(negedge clk);
    check("t4_no_pulse", 32'(en_count - base), 32'd0);
    avs_rd(A_STATUS, s);
    check("t4_queued", 32'(s[15:8]), 32'd1);
    avs_rd(A_RSP, s);
    check("t4_pop", s, 32'h0000_BEEF);
    wait_done("t4_issue");
    check("t4_pulse", 32'(en_count - base), 32'd1);
    avs_rd(A_STATUS, s);
    check("t4_rsp_count", 32'(s[23:16]), 32'd4);
    check("t4_rsp_ovf",   32'(s[4]), 32'd0);
    avs_wr(A_CTRL, 32'd4);

    // Engine misses the first pulse: sequencer re-pulses.
    eng_deaf = 1'b1;
    base = en_count;
    avs_wr(A_DATA, 32'h2000_0055);
    avs_wr(A_PUSH, 32'd1);
    for (int n = 0; n < 20 && en_count == base; n++) @(negedge clk);
    eng_deaf = 1'b0;
    wait_done("t5_repulse");
    check("t5_pulses", 32'(en_count - base), 32'd2);

    // DVSR write mid-transaction applies only to the next command.
    eng_len = 20;
    avs_wr(A_DATA, 32'h2000_0001);
    avs_wr(A_PUSH, 32'd1);
    repeat (6) @(negedge clk);
    avs_wr(A_DVSR, 32'h0000_0100);
    check("t6_dvsr_hold", 32'(i2c_dvsr), 32'd500);
    wait_done("t6a");
    check("t6_dvsr_idle", 32'(i2c_dvsr), 32'd500);
    avs_wr(A_PUSH, 32'd1);
    wait_done("t6b");
    check("t6_dvsr_new", 32'(i2c_dvsr), 32'h0000_0100);

    // Asynchronous reset while waiting for the engine to finish.
    eng_len = 30;
    avs_wr(A_DATA, 32'hA100_0077);
    for (int i = 0; i < 3; i++) avs_wr(A_PUSH, 32'd1);
    repeat (3) @(negedge clk);
    avs_rd(A_STATUS, s);
    check("t7_busy",  32'(s[0]), 32'd1);
    check("t7_count", 32'(s[15:8]), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("t7_readdata", avs_readdata, 32'h0);
    check("t7_en",       32'(i2c_en), 32'h0);
    check("t7_data",     i2c_data, 32'h0);
    check("t7_byteen",   32'(i2c_byteEn), 32'h0);
    check("t7_dvsr",     32'(i2c_dvsr), 32'd500);
    check("t7_irq",      32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    avs_rd(A_STATUS, s);
    check("t7_status", s, 32'h0000_0004);
    avs_rd(A_RSP, s);
    check("t7_rsp", s, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
